// File: rtl/calc_pkg.sv
// Shared calculator types: keypad FSM states, opcode constants and the opcode event record.
package calc_pkg;

  typedef enum logic [1:0] {
    KD_IDLE,
    KD_DEBOUNCE,
    KD_HELD
  } kd_state_e;

  // Event code field is sized for keypads of up to 15 keys.
  localparam int unsigned OPC_CODE_W = 4;

  localparam logic [OPC_CODE_W-1:0] OPC_NONE = 4'd0;
  localparam logic [OPC_CODE_W-1:0] OPC_ADD  = 4'd1;
  localparam logic [OPC_CODE_W-1:0] OPC_SUB  = 4'd2;

  typedef struct packed {
    logic [OPC_CODE_W-1:0] code;
    logic                  is_op;
    logic                  is_result;
    logic                  is_enter;
  } opcode_event_t;

endpackage

// File: rtl/key_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous pad inputs.
module key_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/opcode_keypad_decoder.sv
// Keypad front end: sync, debounce, one opcode event per press, valid/ready output with overrun.
// Optional auto-repeat while a key is held is enabled by defining OPCODE_AUTOREPEAT_EN.
module opcode_keypad_decoder
  import calc_pkg::*;
#(
  parameter int unsigned       N_KEYS          = 8,
  parameter int unsigned       DEBOUNCE_CYCLES = 4,
  parameter logic [N_KEYS-1:0] OP_MASK         = N_KEYS'(8'b0000_0011),
  parameter int unsigned       ENTER_KEY       = 7
`ifdef OPCODE_AUTOREPEAT_EN
  , parameter int unsigned     REPEAT_CYCLES   = 64
`endif
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_KEYS-1:0]             i_keys,
  output logic [$clog2(N_KEYS+1)-1:0]   o_op_code,
  output logic                          o_is_op,
  output logic                          o_is_result,
  output logic                          o_is_enter,
  output logic                          o_op_valid,
  input  logic                          i_op_ready,
  output logic                          o_overrun,
  input  logic                          i_overrun_clr
);

  localparam int unsigned CODE_W = $clog2(N_KEYS + 1);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_KEYS-1:0] w_k_sync;
  logic              w_any;
  logic [CODE_W-1:0] w_key_idx;
  kd_state_e         r_state, w_state_next;
  logic [CODE_W-1:0] r_cand, w_cand_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next, w_cnt_inc;
  logic              w_fsm_strobe, w_rep_strobe, r_strobe;
  opcode_event_t     w_evt, r_evt;
  logic              r_valid, r_overrun;

  key_sync #(.WIDTH(N_KEYS)) u_key_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_keys),
    .o_q   (w_k_sync)
  );

  // Lowest index wins when several keys are down.
  always_comb begin
    w_any     = |w_k_sync;
    w_key_idx = '0;
    for (int i = int'(N_KEYS) - 1; i >= 0; i--) begin
      if (w_k_sync[i]) w_key_idx = CODE_W'(i);
    end
  end

  // r_cnt counts matching samples while debouncing and idle samples while held.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    w_fsm_strobe = 1'b0;
    unique case (r_state)
      KD_IDLE: begin
        if (w_any) begin
          w_cand_next = w_key_idx;
          if (DEBOUNCE_CYCLES <= 1) begin
            w_state_next = KD_HELD;
            w_fsm_strobe = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_state_next = KD_DEBOUNCE;
            w_cnt_next   = CNT_W'(1);
          end
        end
      end
      KD_DEBOUNCE: begin
        if (!w_any) begin
          w_state_next = KD_IDLE;
          w_cnt_next   = '0;
        end else if (w_key_idx != r_cand) begin
          w_cand_next = w_key_idx;
          w_cnt_next  = CNT_W'(1);
        end else if (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
          w_state_next = KD_HELD;
          w_fsm_strobe = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      KD_HELD: begin
        if (w_any) begin
          w_cnt_next = '0;
        end else if (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
          w_state_next = KD_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = KD_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

`ifdef OPCODE_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);

  logic [REP_W-1:0] r_rep, w_rep_next, w_rep_inc;

  always_comb begin
    w_rep_inc    = r_rep + REP_W'(1);
    w_rep_next   = '0;
    w_rep_strobe = 1'b0;
    if (r_state == KD_HELD && w_any && w_key_idx == r_cand) begin
      if (w_rep_inc == REP_W'(REPEAT_CYCLES)) w_rep_strobe = 1'b1;
      else                                    w_rep_next   = w_rep_inc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rep <= '0;
    else       r_rep <= w_rep_next;
  end
`else
  assign w_rep_strobe = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= KD_IDLE;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cand   <= w_cand_next;
      r_cnt    <= w_cnt_next;
      r_strobe <= w_fsm_strobe | w_rep_strobe;
    end
  end

  // r_cand is stable for the cycle after a strobe, so the event is built from it directly.
  always_comb begin
    w_evt       = '0;
    w_evt.code  = OPC_CODE_W'(r_cand) + OPC_CODE_W'(1);
    for (int i = 0; i < int'(N_KEYS); i++) begin
      if (r_cand == CODE_W'(i)) w_evt.is_op = OP_MASK[i];
    end
    w_evt.is_result = w_evt.is_op;
    w_evt.is_enter  = (r_cand == CODE_W'(ENTER_KEY));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_evt     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_strobe) begin
        if (!r_valid || i_op_ready) begin
          r_evt   <= w_evt;
          r_valid <= 1'b1;
        end
      end else if (r_valid && i_op_ready) begin
        r_evt   <= '{code: OPC_NONE, default: 1'b0};
        r_valid <= 1'b0;
      end
      if (r_strobe && r_valid && !i_op_ready) r_overrun <= 1'b1;
      else if (i_overrun_clr)                  r_overrun <= 1'b0;
    end
  end

  assign o_op_code   = r_evt.code[CODE_W-1:0];
  assign o_is_op     = r_evt.is_op;
  assign o_is_result = r_evt.is_result;
  assign o_is_enter  = r_evt.is_enter;
  assign o_op_valid  = r_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_opcode_keypad_decoder.sv
// Scoreboard bench for opcode_keypad_decoder: directed plan items plus randomized key/ready traffic.
// Define OPCODE_AUTOREPEAT_EN to also exercise auto-repeat with a 16-cycle period.
module tb_opcode_keypad_decoder;

  localparam int          D     = 4;
  localparam logic [7:0]  OPM   = 8'b0000_0011;
  localparam int          ENTER = 7;
`ifdef OPCODE_AUTOREPEAT_EN
  localparam int          REP   = 16;
`endif

  typedef struct {
    int edge_n;
    int code;
    int op;
    int enter;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] keys = '0;
  logic       op_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [3:0] o_op_code;
  logic       o_is_op, o_is_result, o_is_enter, o_op_valid, o_overrun;

  opcode_keypad_decoder #(
    .N_KEYS          (8),
    .DEBOUNCE_CYCLES (D),
    .OP_MASK         (OPM),
    .ENTER_KEY       (ENTER)
`ifdef OPCODE_AUTOREPEAT_EN
    , .REPEAT_CYCLES (REP)
`endif
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_keys        (keys),
    .o_op_code     (o_op_code),
    .o_is_op       (o_is_op),
    .o_is_result   (o_is_result),
    .o_is_enter    (o_is_enter),
    .o_op_valid    (o_op_valid),
    .i_op_ready    (op_ready),
    .o_overrun     (o_overrun),
    .i_overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   load_edges[$];
  int   n_loads = 0, n_valid_cyc = 0;
  int   last_code = 0, last_op = 0, last_result = 0, last_enter = 0, last_edge = 0;
  bit   mon_en = 0, prev_valid = 0, prev_hs = 0;

  // Reference model state: key samples as seen by the debouncer, press latch and output slot.
  logic [7:0] m_ks1, m_ks2;
  logic [7:0] opm_v = OPM;
  bit m_latched, m_pend, m_valid, m_overrun;
  int m_run_idx, m_run_len, m_rel, m_rep, m_lat_key, m_pend_key;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int low_idx(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_ks1 = '0; m_ks2 = '0;
    m_latched = 0; m_pend = 0; m_valid = 0; m_overrun = 0;
    m_run_idx = 0; m_run_len = 0; m_rel = 0; m_rep = 0; m_lat_key = 0; m_pend_key = 0;
    sb.delete();
  endtask

  // Advances the model across the upcoming clock edge using the inputs currently driven.
  task automatic model_edge();
    int idx;
    bit ovr_set = 0;
    bit new_pend = 0;
    int new_key = 0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_pend) begin
      if (!m_valid || op_ready) begin
        m_valid = 1;
        sb.push_back('{edge_n: cyc, code: m_pend_key + 1, op: int'(opm_v[m_pend_key]),
                       enter: int'(m_pend_key == ENTER)});
      end else begin
        ovr_set = 1;
      end
    end else if (m_valid && op_ready) begin
      m_valid = 0;
    end
    if (ovr_set) m_overrun = 1;
    else if (overrun_clr) m_overrun = 0;

    idx = low_idx(m_ks2);
    if (!m_latched) begin
      if (idx < 0) m_run_len = 0;
      else begin
        if (m_run_len > 0 && idx == m_run_idx) m_run_len++;
        else begin
          m_run_idx = idx;
          m_run_len = 1;
        end
        if (m_run_len == D) begin
          new_pend = 1; new_key = idx;
          m_latched = 1; m_lat_key = idx;
          m_run_len = 0; m_rel = 0; m_rep = 0;
        end
      end
    end else begin
      if (idx < 0) begin
        m_rel++;
        m_rep = 0;
        if (m_rel == D) begin
          m_latched = 0;
          m_rel = 0;
        end
      end else begin
        m_rel = 0;
`ifdef OPCODE_AUTOREPEAT_EN
        if (idx == m_lat_key) begin
          m_rep++;
          if (m_rep == REP) begin
            new_pend = 1; new_key = idx; m_rep = 0;
          end
        end else begin
          m_rep = 0;
        end
`endif
      end
    end
    m_pend = new_pend;
    m_pend_key = new_key;
    m_ks2 = m_ks1;
    m_ks1 = keys;
  endtask

  task automatic step();
    @(negedge clk);
    #2;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] k, input int n);
    keys = k;
    repeat (n) step();
  endtask

  // Monitor: per-cycle output checks and scoreboard pops on every newly presented event.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("op_valid", int'(o_op_valid), int'(m_valid));
      chk("overrun", int'(o_overrun), int'(m_overrun));
      if (o_op_valid) n_valid_cyc++;
      else chk("idle_outputs", int'({o_op_code, o_is_op, o_is_result, o_is_enter}), 0);
      if (o_op_valid && (!prev_valid || prev_hs)) begin
        n_loads++;
        last_code = int'(o_op_code); last_op = int'(o_is_op);
        last_result = int'(o_is_result); last_enter = int'(o_is_enter);
        last_edge = cyc - 1;
        load_edges.push_back(cyc - 1);
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got code %0d, expected no event (edge %0d)",
                   o_op_code, cyc - 1);
        end else begin
          e = sb.pop_front();
          chk("event_edge", cyc - 1, e.edge_n);
          chk("event_code", int'(o_op_code), e.code);
          chk("event_is_op", int'(o_is_op), e.op);
          chk("event_is_result", int'(o_is_result), e.op);
          chk("event_is_enter", int'(o_is_enter), e.enter);
        end
      end
      prev_valid = o_op_valid;
      prev_hs = o_op_valid && op_ready;
    end
  end

  initial begin
    int base, vbase, p, lbase;
    logic [7:0] k;
    model_reset();
    #3 rst = 1'b1;
    repeat (3) step();
    mon_en = 1;
    chk("reset_valid", int'(o_op_valid), 0);
    chk("reset_code", int'(o_op_code), 0);
    chk("reset_flags", int'({o_is_op, o_is_result, o_is_enter}), 0);
    chk("reset_overrun", int'(o_overrun), 0);
    rst = 1'b0;
    op_ready = 1'b1;
    repeat (2) step();

    // Reset in the middle of a debounce aborts the press.
    base = n_loads;
    keys = 8'h01;
    repeat (3) step();
    rst = 1'b1; keys = 8'h00; model_reset();
    repeat (2) step();
    rst = 1'b0;
    hold(8'h00, 12);
    chk("reset_abort_events", n_loads - base, 0);

    // Single press, always-ready consumer.
    base = n_loads; vbase = n_valid_cyc; p = cyc;
    hold(8'h01, 20);
    hold(8'h00, 8);
    chk("single_events", n_loads - base, 1);
    chk("single_code", last_code, 1);
    chk("single_is_op", last_op, 1);
    chk("single_is_result", last_result, 1);
    chk("single_is_enter", last_enter, 0);
    chk("single_latency", last_edge - p, 2 + D);
    chk("single_valid_cycles", n_valid_cyc - vbase, 1);

    // Short glitch, then bouncing followed by a stable press.
    base = n_loads;
    hold(8'h02, 3);
    hold(8'h00, 8);
    chk("glitch_events", n_loads - base, 0);
    for (int i = 0; i < 3; i++) begin
      hold(8'h02, 2);
      hold(8'h00, 2);
    end
    hold(8'h02, 10);
    hold(8'h00, 8);
    chk("bounce_events", n_loads - base, 1);
    chk("bounce_code", last_code, 2);

    // Priority and enter key.
    base = n_loads;
    hold(8'h81, 12);
    hold(8'h00, 8);
    chk("prio_events", n_loads - base, 1);
    chk("prio_code", last_code, 1);
    hold(8'h80, 12);
    hold(8'h00, 8);
    chk("enter_code", last_code, 8);
    chk("enter_is_enter", last_enter, 1);
    chk("enter_is_op", last_op, 0);

    // Back-pressure: second press is dropped and flags overrun.
    op_ready = 1'b0;
    hold(8'h01, 8);
    hold(8'h00, 8);
    hold(8'h02, 8);
    hold(8'h00, 8);
    chk("bp_code_held", int'(o_op_code), 1);
    chk("bp_valid_held", int'(o_op_valid), 1);
    chk("bp_overrun_set", int'(o_overrun), 1);
    op_ready = 1'b1;
    step();
    chk("bp_pop_valid", int'(o_op_valid), 0);
    chk("bp_pop_code", int'(o_op_code), 0);
    chk("bp_overrun_sticky", int'(o_overrun), 1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("bp_overrun_clr", int'(o_overrun), 0);

`ifdef OPCODE_AUTOREPEAT_EN
    base = n_loads; lbase = load_edges.size(); p = cyc;
    hold(8'h04, 60);
    hold(8'h00, 10);
    chk("repeat_events", n_loads - base, 4);
    chk("repeat_code", last_code, 3);
    for (int i = 0; i < 4; i++) begin
      if (load_edges.size() > lbase + i) chk("repeat_edge", load_edges[lbase + i] - p, 6 + REP * i);
    end
`endif

    // Randomized keys, consumer stalls and overrun clears against the model.
    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 3))
        0:       k = 8'h00;
        1:       k = 8'(1 << $urandom_range(0, 7));
        default: k = 8'($urandom);
      endcase
      keys = k;
      for (int c = 0; c < int'($urandom_range(1, 14)); c++) begin
        op_ready = ($urandom_range(0, 3) != 0);
        overrun_clr = ($urandom_range(0, 9) == 0);
        step();
      end
    end
    op_ready = 1'b1;
    overrun_clr = 1'b0;
    hold(8'h00, 12);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
